// File: rtl/julia_pkg.sv
// Shared defaults, dispatch state encoding and helpers for the Julia
// master/slave demo.
package julia_pkg;

  localparam int unsigned NUM_WRK_DEF = 16;
  localparam int unsigned X_RES_DEF   = 640;
  localparam int unsigned Y_RES_DEF   = 480;
  localparam int unsigned XW_DEF      = 10;
  localparam int unsigned YW_DEF      = 9;

  // Widest worker vector the one-hot helper accepts; narrower masks are zero-extended.
  localparam int unsigned MAX_WRK = 64;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } disp_state_t;

  function automatic logic is_onehot(input logic [MAX_WRK-1:0] v);
    return (v != '0) && ((v & (v - MAX_WRK'(1))) == '0);
  endfunction

endpackage

// File: rtl/raster_cnt.sv
// Raster-order pixel coordinate counter with a last-pixel flag.
module raster_cnt
  import julia_pkg::*;
#(
  parameter int unsigned X_RES = X_RES_DEF,
  parameter int unsigned Y_RES = Y_RES_DEF,
  parameter int unsigned XW    = XW_DEF,
  parameter int unsigned YW    = YW_DEF
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          inc,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == XW'(X_RES - 1));
  assign y_end = (y == YW'(Y_RES - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/job_dispatch.sv
// Hands raster pixels to idle Julia workers selected by mask_gen's rotating
// one-hot mask; one job per cycle at most.
module job_dispatch
  import julia_pkg::*;
#(
  parameter int unsigned NUM_WRK = NUM_WRK_DEF,
  parameter int unsigned X_RES   = X_RES_DEF,
  parameter int unsigned Y_RES   = Y_RES_DEF,
  parameter int unsigned XW      = XW_DEF,
  parameter int unsigned YW      = YW_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [NUM_WRK-1:0] mask,
  input  logic [NUM_WRK-1:0] wrk_busy,
  output logic               shift_enable,
  output logic [NUM_WRK-1:0] job_valid,
  output logic [XW-1:0]      job_x,
  output logic [YW-1:0]      job_y,
  output logic               frame_busy,
  output logic               frame_done,
  output logic               mask_err
);

  disp_state_t   state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last;
  logic          mask_ok;
  logic          hit;
  logic          clr;

  assign mask_ok      = is_onehot(MAX_WRK'(mask));
  assign hit          = (state == SCAN) && mask_ok && (|(mask & ~wrk_busy));
  assign clr          = (state == IDLE) && start;
  assign shift_enable = (state == SCAN);
  assign frame_busy   = (state != IDLE);

  raster_cnt #(
    .X_RES(X_RES),
    .Y_RES(Y_RES),
    .XW   (XW),
    .YW   (YW)
  ) u_raster_cnt (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (clr),
    .inc  (hit),
    .x    (x),
    .y    (y),
    .last (last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      job_valid  <= '0;
      job_x      <= '0;
      job_y      <= '0;
      frame_done <= 1'b0;
      mask_err   <= 1'b0;
    end else begin
      job_valid  <= '0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mask_err <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (!mask_ok) mask_err <= 1'b1;
          if (hit) begin
            job_valid <= mask;
            job_x     <= x;
            job_y     <= y;
            if (last) state <= DONE;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_job_dispatch.sv
// Directed bench for job_dispatch with a mask_gen stand-in and a
// pixel-index reference model compared every cycle.
module tb_job_dispatch;

  localparam int NW = 4;
  localparam int XR = 4;
  localparam int YR = 2;
  localparam int XW = 2;
  localparam int YW = 1;

  logic          clk      = 1'b0;
  logic          n_rst    = 1'b1;
  logic          start    = 1'b0;
  logic [NW-1:0] wrk_busy = '0;
  logic [NW-1:0] mask_reg;
  logic [NW-1:0] mask;
  logic          zero_mask = 1'b0;
  logic          ld        = 1'b0;
  logic [NW-1:0] ld_val    = '0;

  logic          shift_enable;
  logic [NW-1:0] job_valid;
  logic [XW-1:0] job_x;
  logic [YW-1:0] job_y;
  logic          frame_busy;
  logic          frame_done;
  logic          mask_err;

  always #5 clk = ~clk;

  assign mask = zero_mask ? '0 : mask_reg;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)            mask_reg <= 4'b0001;
    else if (ld)           mask_reg <= ld_val;
    else if (shift_enable) mask_reg <= {mask_reg[NW-2:0], mask_reg[NW-1]};
  end

  job_dispatch #(
    .NUM_WRK(NW),
    .X_RES  (XR),
    .Y_RES  (YR),
    .XW     (XW),
    .YW     (YW)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .mask        (mask),
    .wrk_busy    (wrk_busy),
    .shift_enable(shift_enable),
    .job_valid   (job_valid),
    .job_x       (job_x),
    .job_y       (job_y),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .mask_err    (mask_err)
  );

  // Reference model: phase 0 idle, 1 scanning, 2 done; p is the linear pixel index.
  int            ph = 0;
  int            p  = 0;
  logic [NW-1:0] e_vld  = '0;
  int            e_x    = 0;
  int            e_y    = 0;
  bit            e_done = 0;
  bit            e_merr = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ph = 0; p = 0; e_vld = '0; e_x = 0; e_y = 0; e_done = 0; e_merr = 0;
    end else begin
      e_vld  = '0;
      e_done = 0;
      case (ph)
        0: if (start) begin p = 0; e_merr = 0; ph = 1; end
        1: begin
          if ($countones(mask) != 1) e_merr = 1;
          else if ((mask & ~wrk_busy) != '0) begin
            e_vld = mask;
            e_x   = p % XR;
            e_y   = p / XR;
            if (p == XR * YR - 1) ph = 2;
            else p++;
          end
        end
        default: begin e_done = 1; ph = 0; end
      endcase
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit en     = 0;

  logic [NW-1:0] log_v[$];
  int            log_x[$];
  int            log_y[$];
  int            log_t[$];
  int            scan_cnt = 0;
  int            done_cnt = 0;
  int            done_t   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", nm, $time);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (en) begin
      chk("job_valid", int'(job_valid), int'(e_vld));
      if (e_vld != '0 || !n_rst) begin
        chk("job_x", int'(job_x), e_x);
        chk("job_y", int'(job_y), e_y);
      end
      chk("frame_done", int'(frame_done), int'(e_done));
      chk("mask_err", int'(mask_err), int'(e_merr));
      chk("shift_enable", int'(shift_enable), int'(ph == 1));
      chk("frame_busy", int'(frame_busy), int'(ph != 0));
      if (job_valid != '0) begin
        log_v.push_back(job_valid);
        log_x.push_back(int'(job_x));
        log_y.push_back(int'(job_y));
        log_t.push_back(cyc);
      end
      if (frame_done) begin done_cnt++; done_t = cyc; end
      if (shift_enable) scan_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_v.delete(); log_x.delete(); log_y.delete(); log_t.delete();
    scan_cnt = 0;
    done_cnt = 0;
    done_t   = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_mask(input logic [NW-1:0] v);
    ld_val = v;
    ld     = 1'b1;
    tick();
    ld     = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 40) begin tick(); k++; end
    if (done_cnt == 0) timeout(nm);
    tick();
  endtask

  task automatic chk_pixels(input string nm, input int first);
    for (int i = 0; i < log_x.size(); i++) begin
      chk({nm, "_x"}, log_x[i], (first + i) % XR);
      chk({nm, "_y"}, log_y[i], (first + i) / XR);
    end
  endtask

  logic [NW-1:0] exp_v1[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [NW-1:0] exp_v2[8] = '{4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
  int            exp_x[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int            exp_y[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    int k;
    #1 n_rst = 1'b0;
    en = 1;
    #2;
    chk("rst_job_valid", int'(job_valid), 0);
    chk("rst_job_x", int'(job_x), 0);
    chk("rst_job_y", int'(job_y), 0);
    chk("rst_frame_busy", int'(frame_busy), 0);
    chk("rst_mask_err", int'(mask_err), 0);
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;
    tick();

    // 1: all workers idle
    clear_log();
    pulse_start();
    wait_done("t1_done");
    chk("t1_count", log_v.size(), 8);
    for (int i = 0; i < log_v.size() && i < 8; i++) begin
      chk("t1_vld", int'(log_v[i]), int'(exp_v1[i]));
      chk("t1_x", log_x[i], exp_x[i]);
      chk("t1_y", log_y[i], exp_y[i]);
      chk("t1_back_to_back", log_t[i] - log_t[0], i);
    end
    if (log_t.size() > 0) chk("t1_done_lag", done_t - log_t[log_t.size()-1], 1);
    chk("t1_done_pulses", done_cnt, 1);

    // 2: worker 1 busy all frame
    load_mask(4'b0100);
    wrk_busy = 4'b0010;
    clear_log();
    pulse_start();
    wait_done("t2_done");
    wrk_busy = '0;
    chk("t2_count", log_v.size(), 8);
    chk("t2_scan_cycles", scan_cnt, 10);
    for (int i = 0; i < log_v.size() && i < 8; i++) begin
      chk("t2_skip_w1", int'(log_v[i][1]), 0);
      chk("t2_vld", int'(log_v[i]), int'(exp_v2[i]));
    end
    chk_pixels("t2", 0);

    // 3: all busy for 5 scan cycles
    load_mask(4'b0001);
    clear_log();
    wrk_busy = 4'b1111;
    pulse_start();
    repeat (5) tick();
    chk("t3_stall_strobes", log_v.size(), 0);
    chk("t3_stall_cycles", scan_cnt, 5);
    wrk_busy = '0;
    wait_done("t3_done");
    chk("t3_count", log_v.size(), 8);
    if (log_v.size() > 0) chk("t3_first_vld", int'(log_v[0]), 4'b0010);
    chk_pixels("t3", 0);

    // 4: zero mask mid-scan
    load_mask(4'b0001);
    clear_log();
    pulse_start();
    tick();
    zero_mask = 1'b1;
    repeat (3) tick();
    chk("t4_forced_strobes", log_v.size(), 1);
    chk("t4_err_set", int'(mask_err), 1);
    zero_mask = 1'b0;
    wait_done("t4_done");
    chk("t4_count", log_v.size(), 8);
    chk("t4_err_sticky", int'(mask_err), 1);
    chk_pixels("t4", 0);
    clear_log();
    pulse_start();
    chk("t4_err_cleared", int'(mask_err), 0);
    wait_done("t4_done2");

    // 5: async reset at pixel (2,1)
    clear_log();
    pulse_start();
    k = 0;
    while (!(job_valid != '0 && job_x == 2'd2 && job_y == 1'b1) && k < 30) begin tick(); k++; end
    if (k >= 30) timeout("t5_reach_2_1");
    #2 n_rst = 1'b0;
    #1;
    chk("t5_rst_vld", int'(job_valid), 0);
    chk("t5_rst_x", int'(job_x), 0);
    chk("t5_rst_y", int'(job_y), 0);
    chk("t5_rst_shift", int'(shift_enable), 0);
    chk("t5_rst_busy", int'(frame_busy), 0);
    chk("t5_rst_done", int'(frame_done), 0);
    tick();
    tick();
    #2 n_rst = 1'b1;
    tick();
    chk("t5_idle_busy", int'(frame_busy), 0);
    chk("t5_idle_shift", int'(shift_enable), 0);
    clear_log();
    pulse_start();
    wait_done("t5_done");
    chk("t5_count", log_v.size(), 8);
    chk_pixels("t5", 0);

    // 6: start during SCAN and in DONE
    load_mask(4'b0001);
    clear_log();
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(frame_busy && !shift_enable) && k < 30) begin tick(); k++; end
    if (k >= 30) timeout("t6_reach_done");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t6_done_pulses", done_cnt, 1);
    chk("t6_no_restart", int'(frame_busy), 0);
    chk("t6_count", log_v.size(), 8);
    chk_pixels("t6", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule
